control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
Hardwired control unit that drives the single-bus CPU datapath (register file, PC, MAR, MDR, IR, RY, RZ/Z, HI/LO). It fetches an instruction and executes register-register ALU instructions. Each instruction runs as a fixed T-state sequence, and every datapath enable, bus-source select and ALU code comes from this block. It sits beside the CPU datapath and replaces hand-driven control stimulus.

Parameters:
RESET_PC_UNUSED, 0, reserved; the PC reset value is owned by the datapath, so this block has no PC logic.
MEM_WAIT_MAX, 15, maximum T1 stall cycles waiting for mem_ready before entering FAULT.

Ports:
clk  in  1  system clock, rising-edge active
reset  in  1  asynchronous, active-low reset
run  in  1  level; while high, the sequencer starts a new fetch from IDLE
ir  in  32  IR contents, valid from T3 onward
mem_ready  in  1  memory read data is valid on MdataIn this cycle
reg_select  out  16  one-hot; drives both RxSelect and RxOut of the source register
reg_in  out  16  one-hot; drives RxIn of the destination register
pc_out, pc_in, mar_in, mdr_in, md_read, mdr_out, ir_in, ry_in, rz_in  out  1 each  datapath strobes
zlow_out, zhigh_out  out  1 each  each drives both the Select and Out of ZLow/ZHigh
hi_in, lo_in  out  1 each  HI/LO register load
alu_control  out  4  ALU operation code
done  out  1  one-cycle pulse when an instruction completes
fault  out  1  sticky; set on an illegal opcode or memory timeout

Behaviour:
- Reset (reset low, async): state=IDLE; all outputs 0, including fault; wait counter=0. Reset asserted mid-instruction aborts it immediately. No register write may occur after reset assertion.
- Moore outputs: decoded from a registered state only. At most one bus source (reg_select bit, pc_out, mdr_out, zlow_out, zhigh_out) may be active in any cycle.
- Decode fields: opcode=ir[31:27], ra=ir[26:23], rb=ir[22:19], rc=ir[18:15].
- ALU map:
  - ADD 00011->0000, SUB 00100->0001, AND 01001->0010, OR 01010->0011
  - SHR 00101->0100, SHL 00110->0101, MUL 01111->0110, DIV 10000->0111
  - 1111 is reserved for the T0 PC increment
  - Any other opcode is illegal.
- States and transitions:
  - IDLE: all strobes 0. Goes to T0 when run=1.
  - T0: pc_out, mar_in, alu_control=1111, rz_in. Goes to T1.
  - T1: zlow_out, md_read, mdr_in, plus pc_in on the first T1 cycle only. Stays in T1 while mem_ready=0, incrementing the wait counter. Goes to T2 when mem_ready=1. Goes to FAULT when the counter reaches MEM_WAIT_MAX.
  - T2: mdr_out, ir_in. Goes to T3.
  - T3: reg_select[rb], ry_in. Goes to FAULT if the opcode is illegal, otherwise T4.
  - T4: reg_select[rc], alu_control=map(opcode), rz_in. Goes to T5.
  - T5: zlow_out, plus reg_in[ra] (non-MUL/DIV) or lo_in (MUL/DIV). Non-MUL/DIV goes to DONE; MUL/DIV goes to T6.
  - T6: zhigh_out, hi_in. Goes to DONE.
  - DONE: done=1 for one cycle. Goes to T0 if run=1, else IDLE.
  - FAULT: fault=1 with all other outputs 0. Held until reset.
- alu_control is 0000 in every state other than T0 and T4.
- pc_in is asserted exactly once per instruction, so the PC advances by exactly 1 regardless of T1 stall length.
- A write to ra=0 is permitted and generated normally; whether R0 is hardwired is the datapath's concern.
- Dropping run mid-instruction has no effect until DONE.
- Latency: a non-MUL/DIV instruction with no stall is 7 cycles from T0 through DONE; MUL/DIV is 8. Each T1 stall cycle adds one.

Test Plan:
- Reset low for 2 cycles, then high with run=0 -> all outputs 0, state stays IDLE, done=0, fault=0.
- run=1, mem_ready=1 in T1, ir=0x4A920000 -> T3: reg_select=0x0004, ry_in=1. T4: reg_select=0x0010, alu_control=0010, rz_in=1. T5: zlow_out=1, reg_in=0x0020. done pulses 7 cycles after T0 entry.
- Same instruction with mem_ready held low 3 cycles in T1 -> T1 lasts 4 cycles, pc_in high only in its first cycle, and the rest of the sequence is unchanged.
- ir with opcode 01111 (MUL), ra=1, rb=2, rc=3 -> T5: lo_in=1, reg_in=0. T6: zhigh_out=1, hi_in=1. done arrives after 8 cycles.
- ir opcode 11111 -> FAULT entered from T3, fault=1, no reg_in ever asserted. Stays in FAULT with run=1 until reset is pulsed low.
- Assert reset low during T4 -> all outputs drop to 0 asynchronously before the next clk edge, and the block restarts in IDLE.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired control unit for the single-bus CPU datapath: fetches an instruction
// and runs register-register ALU instructions as a fixed T-state sequence.
module control_sequencer #(
    parameter int RESET_PC_UNUSED = 0,
    parameter int MEM_WAIT_MAX    = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic [15:0] reg_select,
    output logic [15:0] reg_in,
    output logic        pc_out,
    output logic        pc_in,
    output logic        mar_in,
    output logic        mdr_in,
    output logic        md_read,
    output logic        mdr_out,
    output logic        ir_in,
    output logic        ry_in,
    output logic        rz_in,
    output logic        zlow_out,
    output logic        zhigh_out,
    output logic        hi_in,
    output logic        lo_in,
    output logic [3:0]  alu_control,
    output logic        done,
    output logic        fault
);
    localparam int CW = $clog2(MEM_WAIT_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_DONE, S_FAULT
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] wait_nxt;
    logic [4:0]    opcode;
    logic [3:0]    ra;
    logic [3:0]    rb;
    logic [3:0]    rc;
    logic [3:0]    alu_op;
    logic          legal;
    logic          mul_div;
    logic          unused_ok;

    assign opcode    = ir[31:27];
    assign ra        = ir[26:23];
    assign rb        = ir[22:19];
    assign rc        = ir[18:15];
    assign wait_nxt  = wait_cnt + CW'(1);
    assign mul_div   = (opcode == 5'b01111) || (opcode == 5'b10000);
    assign unused_ok = &{1'b0, ir[14:0], (RESET_PC_UNUSED != 0)};

    // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        alu_op = 4'b0000;
        legal  = 1'b1;
        case (opcode)
            5'b00011: alu_op = 4'b0000;
            5'b00100: alu_op = 4'b0001;
            5'b01001: alu_op = 4'b0010;
            5'b01010: alu_op = 4'b0011;
            5'b00101: alu_op = 4'b0100;
            5'b00110: alu_op = 4'b0101;
            5'b01111: alu_op = 4'b0110;
            5'b10000: alu_op = 4'b0111;
            default:  legal  = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            case (state)
                S_IDLE:  if (run) state <= S_T0;
                S_T0: begin
                    wait_cnt <= '0;
                    state    <= S_T1;
                end
                S_T1: begin
                    if (mem_ready) begin
                        state <= S_T2;
                    end else begin
                        wait_cnt <= wait_nxt;
                        if (wait_nxt == CW'(MEM_WAIT_MAX)) state <= S_FAULT;
                    end
                end
                S_T2:    state <= S_T3;
                S_T3:    state <= legal ? S_T4 : S_FAULT;
                S_T4:    state <= S_T5;
                S_T5:    state <= mul_div ? S_T6 : S_DONE;
                S_T6:    state <= S_DONE;
                S_DONE:  state <= run ? S_T0 : S_IDLE;
                S_FAULT: state <= S_FAULT;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobes are a pure decode of the registered state, so reset clears them at once.
    always_comb begin
        reg_select  = '0;
        reg_in      = '0;
        pc_out      = 1'b0;
        pc_in       = 1'b0;
        mar_in      = 1'b0;
        mdr_in      = 1'b0;
        md_read     = 1'b0;
        mdr_out     = 1'b0;
        ir_in       = 1'b0;
        ry_in       = 1'b0;
        rz_in       = 1'b0;
        zlow_out    = 1'b0;
        zhigh_out   = 1'b0;
        hi_in       = 1'b0;
        lo_in       = 1'b0;
        alu_control = 4'b0000;
        done        = 1'b0;
        fault       = 1'b0;
        case (state)
            S_T0: begin
                pc_out      = 1'b1;
                mar_in      = 1'b1;
                rz_in       = 1'b1;
                alu_control = 4'b1111;
            end
            S_T1: begin
                zlow_out = 1'b1;
                md_read  = 1'b1;
                mdr_in   = 1'b1;
                pc_in    = (wait_cnt == '0);
            end
            S_T2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
            end
            S_T3: begin
                reg_select = 16'h0001 << rb;
                ry_in      = 1'b1;
            end
            S_T4: begin
                reg_select  = 16'h0001 << rc;
                alu_control = alu_op;
                rz_in       = 1'b1;
            end
            S_T5: begin
                zlow_out = 1'b1;
                if (mul_div) lo_in  = 1'b1;
                else         reg_in = 16'h0001 << ra;
            end
            S_T6: begin
                zhigh_out = 1'b1;
                hi_in     = 1'b1;
            end
            S_DONE:  done  = 1'b1;
            S_FAULT: fault = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer: an instruction-level model plans the
// expected strobe vector per cycle, and one compare process checks every cycle.
module tb_control_sequencer;
    localparam int MEM_WAIT_MAX = 15;

    typedef struct packed {
        logic [15:0] reg_select;
        logic [15:0] reg_in;
        logic        pc_out, pc_in, mar_in, mdr_in, md_read, mdr_out, ir_in, ry_in, rz_in;
        logic        zlow_out, zhigh_out, hi_in, lo_in;
        logic [3:0]  alu_control;
        logic        done, fault;
    } out_t;

    typedef struct {
        out_t        exp;
        logic        mr;
        logic        rn;
        logic [31:0] irv;
        string       ph;
    } step_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        mem_ready = 1'b0;
    logic [31:0] ir = '0;
    logic [15:0] reg_select, reg_in;
    logic        pc_out, pc_in, mar_in, mdr_in, md_read, mdr_out, ir_in, ry_in, rz_in;
    logic        zlow_out, zhigh_out, hi_in, lo_in, done, fault;
    logic [3:0]  alu_control;
    out_t        act;

    control_sequencer #(.RESET_PC_UNUSED(0), .MEM_WAIT_MAX(MEM_WAIT_MAX)) dut (
        .clk(clk), .reset(reset), .run(run), .ir(ir), .mem_ready(mem_ready),
        .reg_select(reg_select), .reg_in(reg_in),
        .pc_out(pc_out), .pc_in(pc_in), .mar_in(mar_in), .mdr_in(mdr_in),
        .md_read(md_read), .mdr_out(mdr_out), .ir_in(ir_in), .ry_in(ry_in), .rz_in(rz_in),
        .zlow_out(zlow_out), .zhigh_out(zhigh_out), .hi_in(hi_in), .lo_in(lo_in),
        .alu_control(alu_control), .done(done), .fault(fault)
    );

    assign act = {reg_select, reg_in, pc_out, pc_in, mar_in, mdr_in, md_read, mdr_out,
                  ir_in, ry_in, rz_in, zlow_out, zhigh_out, hi_in, lo_in, alu_control,
                  done, fault};

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    out_t cur_exp;
    bit   exp_valid = 1'b0;
    string cur_ph;
    int   cur_idx;
    out_t hist[$];
    step_t plan[$];
    logic [3:0] alu_map[logic [4:0]];
    logic [4:0] legal_ops[8];

    task automatic check_out(input string name, input out_t a, input out_t e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, a, e);
        end
    endtask

    task automatic check_int(input string name, input int a, input int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, a, e);
        end
    endtask

    // Single compare process: every planned cycle is checked at the falling edge.
    always @(negedge clk) begin
        if (exp_valid) begin
            check_out($sformatf("%s step %0d", cur_ph, cur_idx), act, cur_exp);
            hist.push_back(act);
        end
    end

    task automatic push(input out_t e, input logic mr, input logic rn,
                        input logic [31:0] irv, input string ph);
        step_t s;
        s.exp = e; s.mr = mr; s.rn = rn; s.irv = irv; s.ph = ph;
        plan.push_back(s);
    endtask

    task automatic plan_idle(input int n, input logic rn);
        for (int i = 0; i < n; i++) push('0, 1'($urandom), rn, $urandom, "IDLE");
    endtask

    task automatic plan_fault();
        out_t e;
        e = '0;
        e.fault = 1'b1;
        for (int i = 0; i < 4; i++) push(e, 1'($urandom), 1'b1, $urandom, "FAULT");
    endtask

    // Instruction-level model: expected strobes for one instruction starting at T0.
    // stalls = number of T1 cycles with mem_ready low before it rises.
    task automatic plan_instr(input logic [31:0] instr, input int stalls, input logic run_done);
        out_t       e;
        logic [4:0] op;
        bit         md;
        op = instr[31:27];
        md = (op == 5'b01111) || (op == 5'b10000);

        e = '0; e.pc_out = 1; e.mar_in = 1; e.rz_in = 1; e.alu_control = 4'hF;
        push(e, 1'($urandom), 1'($urandom), $urandom, "T0");
        for (int i = 0; ; i++) begin
            e = '0; e.zlow_out = 1; e.md_read = 1; e.mdr_in = 1; e.pc_in = (i == 0);
            if (i == stalls) begin
                push(e, 1'b1, 1'($urandom), $urandom, "T1");
                break;
            end
            push(e, 1'b0, 1'($urandom), $urandom, "T1");
            if (i + 1 == MEM_WAIT_MAX) begin
                plan_fault();
                return;
            end
        end
        e = '0; e.mdr_out = 1; e.ir_in = 1;
        push(e, 1'($urandom), 1'($urandom), $urandom, "T2");
        e = '0; e.reg_select[instr[22:19]] = 1'b1; e.ry_in = 1;
        push(e, 1'($urandom), 1'($urandom), instr, "T3");
        if (!alu_map.exists(op)) begin
            plan_fault();
            return;
        end
        e = '0; e.reg_select[instr[18:15]] = 1'b1; e.rz_in = 1; e.alu_control = alu_map[op];
        push(e, 1'($urandom), 1'($urandom), instr, "T4");
        e = '0; e.zlow_out = 1;
        if (md) e.lo_in = 1'b1;
        else    e.reg_in[instr[26:23]] = 1'b1;
        push(e, 1'($urandom), 1'($urandom), instr, "T5");
        if (md) begin
            e = '0; e.zhigh_out = 1; e.hi_in = 1;
            push(e, 1'($urandom), 1'($urandom), instr, "T6");
        end
        e = '0; e.done = 1;
        push(e, 1'($urandom), run_done, instr, "DONE");
    endtask

    // Called at posedge+1; drives each planned cycle. abort_at pulls reset low mid-cycle.
    task automatic exec_plan(input int abort_at);
        hist.delete();
        for (int i = 0; i < plan.size(); i++) begin
            run       = plan[i].rn;
            mem_ready = plan[i].mr;
            ir        = plan[i].irv;
            cur_exp   = plan[i].exp;
            cur_ph    = plan[i].ph;
            cur_idx   = i;
            exp_valid = 1'b1;
            if (i == abort_at) begin
                @(negedge clk);
                #2;
                exp_valid = 1'b0;
                run   = 1'b0;
                reset = 1'b0;
                #1 check_out("abort async drop", act, '0);
                @(posedge clk);
                #1 check_out("abort held", act, '0);
                @(negedge clk);
                reset = 1'b1;
                @(posedge clk);
                #1;
                plan.delete();
                return;
            end
            @(posedge clk);
            #1;
        end
        exp_valid = 1'b0;
        plan.delete();
    endtask

    task automatic pulse_reset();
        run   = 1'b0;
        reset = 1'b0;
        #1 check_out("reset async drop", act, '0);
        @(posedge clk);
        #1 check_out("reset held", act, '0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic int count_hist(input int which);
        int n = 0;
        foreach (hist[i]) begin
            if (which == 0 && hist[i].pc_in) n++;
            if (which == 1 && hist[i].reg_in != 16'h0) n++;
        end
        return n;
    endfunction

    initial begin
        logic [31:0] instr;
        int          st;
        logic        rd;
        bit          faulted;

        alu_map[5'b00011] = 4'h0; alu_map[5'b00100] = 4'h1;
        alu_map[5'b01001] = 4'h2; alu_map[5'b01010] = 4'h3;
        alu_map[5'b00101] = 4'h4; alu_map[5'b00110] = 4'h5;
        alu_map[5'b01111] = 4'h6; alu_map[5'b10000] = 4'h7;
        legal_ops = '{5'b00011, 5'b00100, 5'b01001, 5'b01010,
                      5'b00101, 5'b00110, 5'b01111, 5'b10000};

        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_out("reset state", act, '0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        plan_idle(3, 1'b0);
        plan_idle(1, 1'b1);
        exec_plan(-1);

        // AND r5 <- r2 & r4, no stall
        plan_instr(32'h4A92_0000, 0, 1'b1);
        exec_plan(-1);
        check_int("and T3 reg_select", hist[3].reg_select, 16'h0004);
        check_int("and T3 ry_in", hist[3].ry_in, 1);
        check_int("and T4 reg_select", hist[4].reg_select, 16'h0010);
        check_int("and T4 alu", hist[4].alu_control, 2);
        check_int("and T5 reg_in", hist[5].reg_in, 16'h0020);
        check_int("and T5 zlow_out", hist[5].zlow_out, 1);
        check_int("and done at 6", hist[6].done, 1);

        // Same instruction with three stall cycles in T1
        plan_instr(32'h4A92_0000, 3, 1'b1);
        exec_plan(-1);
        check_int("stall pc_in count", count_hist(0), 1);
        check_int("stall pc_in first", hist[1].pc_in, 1);
        check_int("stall pc_in second", hist[2].pc_in, 0);
        check_int("stall T1 last", hist[4].md_read, 1);
        check_int("stall done at 9", hist[9].done, 1);

        // MUL r1 <- r2 * r3
        plan_instr({5'b01111, 4'd1, 4'd2, 4'd3, 15'd0}, 0, 1'b0);
        exec_plan(-1);
        check_int("mul T4 alu", hist[4].alu_control, 6);
        check_int("mul T5 lo_in", hist[5].lo_in, 1);
        check_int("mul T5 reg_in", hist[5].reg_in, 0);
        check_int("mul T6 hi_in", hist[6].hi_in, 1);
        check_int("mul T6 zhigh_out", hist[6].zhigh_out, 1);
        check_int("mul done at 7", hist[7].done, 1);
        plan_idle(2, 1'b0);
        plan_idle(1, 1'b1);
        exec_plan(-1);

        for (int n = 0; n < 80; n++) begin
            instr = $urandom;
            if ($urandom_range(0, 9) != 0) instr[31:27] = legal_ops[$urandom_range(0, 7)];
            st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, MEM_WAIT_MAX + 1)) : 0;
            rd = ($urandom_range(0, 3) != 0);
            plan_instr(instr, st, rd);
            faulted = plan[plan.size() - 1].exp.fault;
            exec_plan(-1);
            if (faulted) begin
                pulse_reset();
                plan_idle(1, 1'b1);
                exec_plan(-1);
            end else if (!rd) begin
                plan_idle($urandom_range(0, 3), 1'b0);
                plan_idle(1, 1'b1);
                exec_plan(-1);
            end
        end

        // Illegal opcode faults from T3 and holds with run high
        plan_instr({5'b11111, 27'h2AB_CDEF}, 0, 1'b1);
        exec_plan(-1);
        check_int("illegal fault at 4", hist[4].fault, 1);
        check_int("illegal fault held", hist[7].fault, 1);
        check_int("illegal no reg_in", count_hist(1), 0);
        pulse_reset();
        plan_idle(1, 1'b1);
        exec_plan(-1);

        // Memory timeout
        plan_instr(32'h1A92_0000, MEM_WAIT_MAX, 1'b1);
        exec_plan(-1);
        check_int("timeout last T1", hist[MEM_WAIT_MAX].md_read, 1);
        check_int("timeout fault", hist[MEM_WAIT_MAX + 1].fault, 1);
        pulse_reset();
        plan_idle(1, 1'b1);
        exec_plan(-1);

        // Reset during T4, then restart from IDLE
        plan_instr(32'h4A92_0000, 0, 1'b1);
        exec_plan(4);
        plan_idle(2, 1'b0);
        plan_idle(1, 1'b1);
        plan_instr(32'h1A92_0000, 0, 1'b0);
        plan_idle(2, 1'b0);
        exec_plan(-1);
        check_int("restart done", hist[9].done, 1);
        check_int("restart reg_in", hist[8].reg_in, 16'h0020);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
